// File: rtl/taus_urng.sv
// Dual taus88 uniform generator feeding the Box-Muller AWGN datapath.
// Produces 64 random bits per accepted sample behind a single-entry output register.
module taus_urng #(
  parameter logic [31:0] SEED_A1 = 32'h0000_3039,
  parameter logic [31:0] SEED_A2 = 32'h0001_E240,
  parameter logic [31:0] SEED_A3 = 32'h0012_D687,
  parameter logic [31:0] SEED_B1 = 32'h0BC6_14E0,
  parameter logic [31:0] SEED_B2 = 32'h075B_CD15,
  parameter logic [31:0] SEED_B3 = 32'h3ADE_68B1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        seed_we,
  input  logic [2:0]  seed_addr,
  input  logic [31:0] seed_data,
  output logic [31:0] seed_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] u0,
  output logic [15:0] u1,
  output logic [31:0] sample_cnt
);

  logic [31:0] a1, a2, a3, b1, b2, b3;
  logic [31:0] na1, na2, na3, nb1, nb2, nb3;
  logic [31:0] ra, rb;
  logic        advance, accept;

  function automatic logic [31:0] step_c1(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 13) ^ s) >> 19;
    return ((s & 32'hFFFF_FFFE) << 12) ^ t;
  endfunction

  function automatic logic [31:0] step_c2(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 2) ^ s) >> 25;
    return ((s & 32'hFFFF_FFF8) << 4) ^ t;
  endfunction

  function automatic logic [31:0] step_c3(input logic [31:0] s);
    logic [31:0] t;
    t = ((s << 3) ^ s) >> 11;
    return ((s & 32'hFFFF_FFF0) << 17) ^ t;
  endfunction

  always_comb begin
    na1 = step_c1(a1);
    na2 = step_c2(a2);
    na3 = step_c3(a3);
    nb1 = step_c1(b1);
    nb2 = step_c2(b2);
    nb3 = step_c3(b3);
    ra  = na1 ^ na2 ^ na3;
    rb  = nb1 ^ nb2 ^ nb3;
  end

  // Handshake: a sample transfers on any rising edge where out_valid && out_ready.
  // While out_valid && !out_ready everything holds; a seed write always wins and
  // discards the pending sample without counting it.
  assign accept  = out_valid && out_ready;
  assign advance = en && !seed_we && (!out_valid || out_ready);

  always_comb begin
    case (seed_addr)
      3'd0:    seed_rdata = a1;
      3'd1:    seed_rdata = a2;
      3'd2:    seed_rdata = a3;
      3'd3:    seed_rdata = b1;
      3'd4:    seed_rdata = b2;
      3'd5:    seed_rdata = b3;
      default: seed_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1         <= SEED_A1;
      a2         <= SEED_A2;
      a3         <= SEED_A3;
      b1         <= SEED_B1;
      b2         <= SEED_B2;
      b3         <= SEED_B3;
      out_valid  <= 1'b0;
      u0         <= 48'h0;
      u1         <= 16'h0;
      sample_cnt <= 32'h0;
    end else if (seed_we) begin
      // Clamp bits keep every component above its taus88 degenerate range.
      case (seed_addr)
        3'd0:    a1 <= seed_data | 32'h2;
        3'd1:    a2 <= seed_data | 32'h8;
        3'd2:    a3 <= seed_data | 32'h10;
        3'd3:    b1 <= seed_data | 32'h2;
        3'd4:    b2 <= seed_data | 32'h8;
        3'd5:    b3 <= seed_data | 32'h10;
        default: ;
      endcase
      out_valid <= 1'b0;
    end else if (advance) begin
      a1        <= na1;
      a2        <= na2;
      a3        <= na3;
      b1        <= nb1;
      b2        <= nb2;
      b3        <= nb3;
      u0        <= {ra, rb[31:16]};
      u1        <= rb[15:0];
      out_valid <= 1'b1;
      if (accept && sample_cnt != 32'hFFFF_FFFF)
        sample_cnt <= sample_cnt + 32'd1;
    end else if (accept) begin
      out_valid <= 1'b0;
      if (sample_cnt != 32'hFFFF_FFFF)
        sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule
